// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter.
package adder_arbiter_pkg;

  // Controller states: accept a request, compute it, then hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester identifiers as carried on rsp_id and stored as last_grant.
  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage : adder_arbiter_pkg

// File: rtl/adder_arbiter_add_sub_unit.sv
// Combinational WIDTH-bit adder/subtractor shared by both requesters.
// Subtraction is a + ~b + 1, so carry_o = 1 means "no borrow".
module add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   total;

  // Fold subtract into the adder: invert b and force the carry-in to 1,
  // which is why the requester's cin is ignored for subtraction.
  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    c_eff = sub_i ? 1'b1 : cin_i;
    total = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
  end

  assign sum_o   = total[WIDTH-1:0];
  assign carry_o = total[WIDTH];

endmodule : add_sub_unit

// File: rtl/adder_arbiter.sv
// Two requesters share one add/subtract unit through a round-robin
// arbiter. Each operation walks IDLE -> EXEC -> RESP -> IDLE, so the
// unit completes at most one operation every three cycles.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic             op_sub_q, op_sub_d;
  logic             op_id_q, op_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_id_q, rsp_id_d;

  logic             grant_en;
  logic             grant_id;
  logic [WIDTH-1:0] unit_sum;
  logic             unit_carry;

  // Round-robin pick: only in IDLE and never while reset is asserted;
  // on contention the requester that did not win last time gets the unit.
  always_comb begin
    grant_en = 1'b0;
    grant_id = ID_REQ0;
    if (rst_n && (state_q == IDLE) && (req0_valid || req1_valid)) begin
      grant_en = 1'b1;
      if (req0_valid && req1_valid) begin
        grant_id = ~last_grant_q;
      end else if (req0_valid) begin
        grant_id = ID_REQ0;
      end else begin
        grant_id = ID_REQ1;
      end
    end
  end

  assign req0_ready = grant_en && (grant_id == ID_REQ0);
  assign req1_ready = grant_en && (grant_id == ID_REQ1);

  // Operands are latched at acceptance so later input changes cannot
  // disturb the operation already in flight.
  add_sub_unit #(
    .WIDTH(WIDTH)
  ) u_add_sub (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .cin_i  (op_cin_q),
    .sub_i  (op_sub_q),
    .sum_o  (unit_sum),
    .carry_o(unit_carry)
  );

  // Next-state logic for the controller, operand latch and response registers.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_cin_d     = op_cin_q;
    op_sub_d     = op_sub_q;
    op_id_d      = op_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d      = EXEC;
          last_grant_d = grant_id;
          op_id_d      = grant_id;
          op_a_d       = (grant_id == ID_REQ1) ? req1_a   : req0_a;
          op_b_d       = (grant_id == ID_REQ1) ? req1_b   : req0_b;
          op_cin_d     = (grant_id == ID_REQ1) ? req1_cin : req0_cin;
          op_sub_d     = (grant_id == ID_REQ1) ? req1_sub : req0_sub;
        end
      end
      EXEC: begin
        rsp_sum_d   = unit_sum;
        rsp_carry_d = unit_carry;
        rsp_id_d    = op_id_q;
        state_d     = RESP;
      end
      RESP: begin
        // No grant is possible here, so a handshake cycle never overlaps
        // with acceptance of the next operation.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State update; reset drops any in-flight operation and hands req0 the
  // first win by pretending req1 was granted last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_REQ1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      op_sub_q     <= 1'b0;
      op_id_q      <= ID_REQ0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= ID_REQ0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_cin_q     <= op_cin_d;
      op_sub_q     <= op_sub_d;
      op_id_q      <= op_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vectors, contention,
// backpressure and mid-operation reset, then randomized traffic, all
// compared against a transaction-level reference model.
module tb_adder_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req0_sub = 1'b0, req1_cin = 1'b0, req1_sub = 1'b0;
  logic         req0_ready, req1_ready;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;

  // Reference model: one outstanding operation, its age in cycles since
  // acceptance, the round-robin memory and the value the response must hold.
  bit           m_pend = 1'b0;
  int           m_age  = 0;
  bit           m_last = 1'b1;
  logic [W-1:0] m_exp_sum = '0, m_hold_sum = '0;
  bit           m_exp_carry = 1'b0, m_hold_carry = 1'b0;
  bit           m_exp_id = 1'b0, m_hold_id = 1'b0;
  logic         obs_r0, obs_r1;
  int           rsp_ids[$];

  adder_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_cin  (req0_cin),
    .req0_sub  (req0_sub),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_cin  (req1_cin),
    .req1_sub  (req1_sub),
    .req1_ready(req1_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Plain arithmetic reference for one operation.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output logic [W-1:0] s, output bit c);
    int t;
    if (sub) begin
      t = int'(a) - int'(b);
      s = W'(t & 255);
      c = (a >= b);
    end else begin
      t = int'(a) + int'(b) + int'(cin);
      s = W'(t % 256);
      c = (t >= 256);
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    bit gok, gid, rv;
    @(negedge clk);
    gok = rst_n && !m_pend && (req0_valid || req1_valid);
    gid = (req0_valid && req1_valid) ? !m_last : !req0_valid;
    rv  = m_pend && (m_age == 2);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    check("req0_ready", 32'(req0_ready), 32'(gok && !gid));
    check("req1_ready", 32'(req1_ready), 32'(gok && gid));
    check("busy", 32'(busy), 32'(m_pend));
    check("rsp_valid", 32'(rsp_valid), 32'(rv));
    check("rsp_sum", 32'(rsp_sum), 32'(m_hold_sum));
    check("rsp_carry", 32'(rsp_carry), 32'(m_hold_carry));
    check("rsp_id", 32'(rsp_id), 32'(m_hold_id));
    if (!rst_n) begin
      m_pend = 1'b0;
      m_last = 1'b1;
      m_hold_sum = '0;
      m_hold_carry = 1'b0;
      m_hold_id = 1'b0;
    end else if (rv && rsp_ready) begin
      m_pend = 1'b0;
      n_rsp++;
      rsp_ids.push_back(int'(m_hold_id));
      $display("[TB] rsp %0d id=%0d sum=%02h carry=%0d", n_rsp, m_hold_id, m_hold_sum, m_hold_carry);
    end else if (m_pend && m_age == 1) begin
      m_age = 2;
      m_hold_sum = m_exp_sum;
      m_hold_carry = m_exp_carry;
      m_hold_id = m_exp_id;
    end else if (gok) begin
      m_pend = 1'b1;
      m_age  = 1;
      m_last = gid;
      m_exp_id = gid;
      if (gid) ref_op(req1_a, req1_b, req1_cin, req1_sub, m_exp_sum, m_exp_carry);
      else     ref_op(req0_a, req0_b, req0_cin, req0_sub, m_exp_sum, m_exp_carry);
    end
    @(posedge clk);
    #1;
  endtask

  // Single req0 operation with the consumer always ready; operands are
  // scrambled right after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [W-1:0] xs, input logic xc);
    int base;
    base = n_rsp;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub;
    tick();
    req0_valid = 1'b0; req0_a = ~a; req0_b = ~b; req0_cin = ~cin; req0_sub = ~sub;
    tick();
    tick();
    check("vec_count", 32'(n_rsp - base), 32'd1);
    check("vec_sum", 32'(rsp_sum), 32'(xs));
    check("vec_carry", 32'(rsp_carry), 32'(xc));
    check("vec_id", 32'(rsp_id), 32'd0);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with both requesters asserting: no ready, reset outputs.
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Directed arithmetic vectors, including cin ignored on subtract.
    do_op(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0);
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    do_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
    do_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);
    do_op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);

    // Contention from reset: grants and responses alternate req0, req1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    base = rsp_ids.size();
    for (int i = 0; i < 12; i++) begin
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom); req0_sub = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom); req1_sub = 1'($urandom);
      tick();
    end
    check("rr_count", 32'(rsp_ids.size() - base), 32'd4);
    for (int k = 0; k < 4 && base + k < rsp_ids.size(); k++)
      check("rr_order", 32'(rsp_ids[base + k]), 32'(k % 2));

    // Backpressure: consumer stalls five cycles in RESP.
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
    base = n_rsp;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h0F; req0_cin = 1'b1; req0_sub = 1'b0;
    tick();
    req1_valid = 1'b1; req0_a = 8'h00; req1_a = 8'hFF;
    repeat (6) tick();
    check("bp_no_rsp", 32'(n_rsp - base), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("bp_rsp", 32'(n_rsp - base), 32'd1);
    check("bp_sum", 32'(rsp_sum), 32'h4C);

    // Reset during EXEC: operation discarded, req0 wins the next contention.
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
    req0_valid = 1'b1;
    tick();
    base = n_rsp;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    check("rst_grant_r0", 32'(obs_r0), 32'd1);
    check("rst_grant_r1", 32'(obs_r1), 32'd0);
    check("rst_no_rsp", 32'(n_rsp - base), 32'd0);

    // Randomized traffic with occasional resets and random backpressure.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom); req0_sub = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom); req1_sub = 1'($urandom);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick();
    check("drained", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adder_arbiter
